// File: rtl/io_bus_pkg.sv
// Shared types and constants for the peripheral IO bus arbiter.
package io_bus_pkg;

    // Access sequencing: wait for a request, run one bus access, then one completion cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Master indices as used by the round-robin grant and the owner register.
    localparam logic MASTER_CPU = 1'b0;
    localparam logic MASTER_AUX = 1'b1;

    // Read data returned to a master whose access ran out of time.
    localparam logic [31:0] DEFAULT_ERR_VALUE = 32'hDEAD_BEEF;

endpackage

// File: rtl/io_rr_arbiter.sv
// Two-way round-robin picker: a lone request wins, and on a tie the master
// that did not win last time is chosen. Purely combinational.
module io_rr_arbiter
    import io_bus_pkg::*;
(
    input  logic [1:0] Req,
    input  logic       LastGrant,
    output logic       GrantIdx,
    output logic       Valid
);

    // Pick the winner from the current requests and the previous grant.
    always_comb begin
        Valid    = |Req;
        GrantIdx = MASTER_CPU;
        if (Req == 2'b11) begin
            GrantIdx = ~LastGrant;
        end else if (Req[1]) begin
            GrantIdx = MASTER_AUX;
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Shares one peripheral IO bus between the CPU port (M0) and a second master (M1).
//
// Handshake: a master raises Mx_Req with its Write/Address/DataOut and holds them
// until Mx_Ack. Mx_Ack is a one-cycle pulse; Mx_Err and Mx_DataIn are valid with it,
// and Mx_DataIn holds until that master's next ack. On the peripheral side P_Sel
// marks an access in progress with P_Write/P_Address/P_DataOut stable throughout;
// the access ends in the cycle the peripheral raises P_Ready, or after TIMEOUT
// cycles without it (TIMEOUT = 0 waits forever).
module io_bus_arbiter
    import io_bus_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 9,
    parameter int                    TIMEOUT    = 16,
    parameter logic [DATA_WIDTH-1:0] ERR_VALUE  = DATA_WIDTH'(DEFAULT_ERR_VALUE)
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  M0_Req,
    input  logic                  M0_Write,
    input  logic [ADDR_WIDTH-1:0] M0_Address,
    input  logic [DATA_WIDTH-1:0] M0_DataOut,
    output logic                  M0_Ack,
    output logic                  M0_Err,
    output logic [DATA_WIDTH-1:0] M0_DataIn,
    input  logic                  M1_Req,
    input  logic                  M1_Write,
    input  logic [ADDR_WIDTH-1:0] M1_Address,
    input  logic [DATA_WIDTH-1:0] M1_DataOut,
    output logic                  M1_Ack,
    output logic                  M1_Err,
    output logic [DATA_WIDTH-1:0] M1_DataIn,
    output logic                  P_Sel,
    output logic                  P_Write,
    output logic [ADDR_WIDTH-1:0] P_Address,
    output logic [DATA_WIDTH-1:0] P_DataOut,
    input  logic [DATA_WIDTH-1:0] P_DataIn,
    input  logic                  P_Ready,
    output state_t                DebugState
);

    // Counter is at least one bit wide so TIMEOUT = 0 still elaborates.
    localparam int            CW          = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int            TO_LAST_I   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] TO_LAST     = CW'(TO_LAST_I);
    localparam bit            HAS_TIMEOUT = (TIMEOUT != 0);

    state_t                state;
    state_t                nextState;
    logic                  owner;
    logic                  latWrite;
    logic [ADDR_WIDTH-1:0] latAddress;
    logic [DATA_WIDTH-1:0] latData;
    logic [CW-1:0]         waitCount;
    logic                  lastGrant;
    logic                  errFlag;
    logic                  grantIdx;
    logic                  grantValid;
    logic                  loadGrant;
    logic                  finishOk;
    logic                  finishTimeout;
    logic                  doneCycle;

    io_rr_arbiter uArb (
        .Req       ({M1_Req, M0_Req}),
        .LastGrant (lastGrant),
        .GrantIdx  (grantIdx),
        .Valid     (grantValid)
    );

    // State register; reset abandons any access without acknowledging it.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state, per-cycle strobes and bus/ack outputs.
    always_comb begin
        nextState     = state;
        loadGrant     = 1'b0;
        finishOk      = 1'b0;
        finishTimeout = 1'b0;
        doneCycle     = 1'b0;
        P_Sel         = 1'b0;
        case (state)
            IDLE: begin
                if (grantValid) begin
                    loadGrant = 1'b1;
                    nextState = ACCESS;
                end
            end
            ACCESS: begin
                P_Sel = 1'b1;
                // A ready peripheral beats a timeout landing in the same cycle.
                if (P_Ready) begin
                    finishOk  = 1'b1;
                    nextState = DONE;
                end else if (HAS_TIMEOUT && (waitCount == TO_LAST)) begin
                    finishTimeout = 1'b1;
                    nextState     = DONE;
                end
            end
            DONE: begin
                doneCycle = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
        P_Write    = P_Sel & latWrite;
        P_Address  = P_Sel ? latAddress : '0;
        P_DataOut  = P_Sel ? latData : '0;
        M0_Ack     = doneCycle & (owner == MASTER_CPU);
        M1_Ack     = doneCycle & (owner == MASTER_AUX);
        M0_Err     = M0_Ack & errFlag;
        M1_Err     = M1_Ack & errFlag;
        DebugState = state;
    end

    // Latched request, wait counter, round-robin history and per-master read data.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            owner      <= MASTER_CPU;
            latWrite   <= 1'b0;
            latAddress <= '0;
            latData    <= '0;
            waitCount  <= '0;
            lastGrant  <= MASTER_AUX;
            errFlag    <= 1'b0;
            M0_DataIn  <= '0;
            M1_DataIn  <= '0;
        end else begin
            if (loadGrant) begin
                owner      <= grantIdx;
                lastGrant  <= grantIdx;
                latWrite   <= grantIdx ? M1_Write   : M0_Write;
                latAddress <= grantIdx ? M1_Address : M0_Address;
                latData    <= grantIdx ? M1_DataOut : M0_DataOut;
                waitCount  <= '0;
            end
            if (P_Sel) begin
                waitCount <= waitCount + CW'(1);
            end
            if (doneCycle) begin
                waitCount <= '0;
            end
            if (finishOk) begin
                errFlag <= 1'b0;
                if (!latWrite) begin
                    if (owner == MASTER_AUX) M1_DataIn <= P_DataIn;
                    else                     M0_DataIn <= P_DataIn;
                end
            end
            if (finishTimeout) begin
                errFlag <= 1'b1;
                if (!latWrite) begin
                    if (owner == MASTER_AUX) M1_DataIn <= ERR_VALUE;
                    else                     M0_DataIn <= ERR_VALUE;
                end
            end
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: directed table, hand sequences, random groups.
module tb_io_bus_arbiter;
    import io_bus_pkg::*;

    localparam int DW      = 32;
    localparam int AW      = 9;
    localparam int TIMEOUT = 16;
    localparam logic [DW-1:0] ERRV = 32'hDEAD_BEEF;
    localparam int REC_W   = 42;   // {master, err, datain[31:0], latency[7:0]}

    logic          CLK = 1'b0;
    logic          Reset;
    logic          M0_Req, M0_Write, M1_Req, M1_Write;
    logic [AW-1:0] M0_Address, M1_Address;
    logic [DW-1:0] M0_DataOut, M1_DataOut;
    logic          M0_Ack, M0_Err, M1_Ack, M1_Err;
    logic [DW-1:0] M0_DataIn, M1_DataIn;
    logic          P_Sel, P_Write, P_Ready;
    logic [AW-1:0] P_Address;
    logic [DW-1:0] P_DataOut, P_DataIn;
    state_t        DebugState;

    io_bus_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TIMEOUT), .ERR_VALUE(ERRV)) dut (
        .CLK(CLK), .Reset(Reset),
        .M0_Req(M0_Req), .M0_Write(M0_Write), .M0_Address(M0_Address), .M0_DataOut(M0_DataOut),
        .M0_Ack(M0_Ack), .M0_Err(M0_Err), .M0_DataIn(M0_DataIn),
        .M1_Req(M1_Req), .M1_Write(M1_Write), .M1_Address(M1_Address), .M1_DataOut(M1_DataOut),
        .M1_Ack(M1_Ack), .M1_Err(M1_Err), .M1_DataIn(M1_DataIn),
        .P_Sel(P_Sel), .P_Write(P_Write), .P_Address(P_Address), .P_DataOut(P_DataOut),
        .P_DataIn(P_DataIn), .P_Ready(P_Ready), .DebugState(DebugState)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [REC_W-1:0] exp_q[$];
    int               wait_q[$];
    logic [DW-1:0]    rd_q[$];
    logic             req_wr[2];
    logic [AW-1:0]    req_addr[2];
    logic [DW-1:0]    req_data[2];
    logic [DW-1:0]    pred_din[2];   // model's view of each master's DataIn
    logic [DW-1:0]    seen_din[2];   // value each DataIn should currently hold
    logic             pred_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic clear_model();
        pred_last = 1'b1;
        for (int i = 0; i < 2; i++) begin
            pred_din[i] = '0;
            seen_din[i] = '0;
        end
    endtask

    // Queue one expected completion together with the peripheral behaviour for it.
    task automatic push_exp(input logic m, input logic err, input logic [DW-1:0] din,
                            input int lat, input int waits, input logic [DW-1:0] rd);
        exp_q.push_back({m, err, din, 8'(lat)});
        wait_q.push_back(waits);
        rd_q.push_back(rd);
        pred_din[m] = din;
        pred_last   = m;
    endtask

    // Reference model: round-robin order, outcome and latency for one group of requests.
    task automatic model_group(input logic want0, input logic want1);
        logic order[2];
        int   n;
        n = 0;
        if (want0 && want1) begin
            order[0] = ~pred_last;
            order[1] = pred_last;
            n = 2;
        end else begin
            order[0] = want1;
            n = 1;
        end
        for (int i = 0; i < n; i++) begin
            int r, w, acc;
            logic err;
            logic [DW-1:0] rd, din;
            r = $urandom_range(0, 9);
            if (r < 7)       w = $urandom_range(0, 4);
            else if (r == 7) w = TIMEOUT - 1;
            else if (r == 8) w = TIMEOUT;
            else             w = $urandom_range(TIMEOUT + 1, TIMEOUT + 9);
            rd  = $urandom;
            err = (w >= TIMEOUT);
            acc = err ? TIMEOUT : w + 1;
            din = req_wr[order[i]] ? pred_din[order[i]] : (err ? ERRV : rd);
            // a back-to-back second grant spends one extra cycle passing through IDLE
            push_exp(order[i], err, din, acc + 1 + i, w, rd);
        end
    endtask

    // Driver + peripheral + checker for one group of simultaneous requests.
    task automatic run_group(input logic want0, input logic want1, input int n_acc);
        int t, n_in, acks, guard;
        logic m;
        logic [REC_W-1:0] e;
        M0_Req = want0; M0_Write = req_wr[0]; M0_Address = req_addr[0]; M0_DataOut = req_data[0];
        M1_Req = want1; M1_Write = req_wr[1]; M1_Address = req_addr[1]; M1_DataOut = req_data[1];
        P_Ready = 1'b0;
        t = 0; n_in = 0; acks = 0; guard = 0;
        while (acks < n_acc && guard < 100) begin
            tick();
            t++; guard++;
            if (M0_Ack || M1_Ack) begin
                chk("ack_expected", exp_q.size() > 0, 1);
                if (exp_q.size() == 0) break;
                e = exp_q.pop_front();
                void'(wait_q.pop_front());
                void'(rd_q.pop_front());
                m = e[41];
                chk("ack_owner", {M1_Ack, M0_Ack}, m ? 2'b10 : 2'b01);
                chk("err", m ? M1_Err : M0_Err, e[40]);
                chk("datain", m ? M1_DataIn : M0_DataIn, e[39:8]);
                chk("other_err", m ? M0_Err : M1_Err, 0);
                chk("other_datain", m ? M0_DataIn : M1_DataIn, seen_din[~m]);
                chk("latency", t, e[7:0]);
                chk("psel_in_done", P_Sel, 0);
                chk("state_done", DebugState, DONE);
                seen_din[m] = e[39:8];
                if (m) M1_Req = 1'b0; else M0_Req = 1'b0;
                acks++; t = 0; n_in = 0; P_Ready = 1'b0;
            end else if (P_Sel) begin
                chk("access_expected", exp_q.size() > 0, 1);
                if (exp_q.size() == 0) break;
                n_in++;
                m = exp_q[0][41];
                chk("p_write", P_Write, req_wr[m]);
                chk("p_address", P_Address, req_addr[m]);
                chk("p_dataout", P_DataOut, req_data[m]);
                chk("state_access", DebugState, ACCESS);
                P_Ready  = (n_in == wait_q[0] + 1);
                P_DataIn = rd_q[0];
            end else begin
                P_Ready = 1'b0;
            end
        end
        chk("group_done", acks, n_acc);
        exp_q.delete(); wait_q.delete(); rd_q.delete();
        M0_Req = 1'b0; M1_Req = 1'b0; P_Ready = 1'b0;
        tick();
        chk("ack_one_cycle", {M1_Ack, M0_Ack}, 2'b00);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic          m;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            waits;
        logic [DW-1:0] rd;
        logic          exp_err;
        logic          exp_keep;   // DataIn must keep its previous value
        logic [DW-1:0] exp_din;
        int            exp_lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1'b0, 1'b1, 9'd40,  32'h0000_0055, 0,  32'h0,         1'b0, 1'b1, 32'h0,         2};
        vecs[1] = '{1'b1, 1'b0, 9'd41,  32'h0,         3,  32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678, 5};
        vecs[2] = '{1'b0, 1'b0, 9'd100, 32'h0,         99, 32'h1111_2222, 1'b1, 1'b0, 32'hDEAD_BEEF, 17};
        vecs[3] = '{1'b0, 1'b0, 9'd101, 32'h0,         1,  32'hCAFE_0001, 1'b0, 1'b0, 32'hCAFE_0001, 3};
        vecs[4] = '{1'b1, 1'b0, 9'd7,   32'h0,         15, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0BAD_F00D, 17};
        vecs[5] = '{1'b1, 1'b1, 9'h1FF, 32'hFFFF_FFFF, 16, 32'h5555_AAAA, 1'b1, 1'b1, 32'h0,         17};
        vecs[6] = '{1'b0, 1'b1, 9'd0,   32'h0000_A5A5, 2,  32'h7777_7777, 1'b0, 1'b1, 32'h0,         4};
    end

    // ---------------- main sequence ----------------
    initial begin
        Reset = 1'b1;
        M0_Req = 0; M0_Write = 0; M0_Address = '0; M0_DataOut = '0;
        M1_Req = 0; M1_Write = 0; M1_Address = '0; M1_DataOut = '0;
        P_Ready = 0; P_DataIn = '0;
        for (int i = 0; i < 2; i++) begin
            req_wr[i] = 1'b0; req_addr[i] = '0; req_data[i] = '0;
        end
        clear_model();
        tick(); tick();

        // reset state
        chk("rst_acks", {M1_Ack, M0_Ack, M1_Err, M0_Err}, 4'b0);
        chk("rst_m0_datain", M0_DataIn, 0);
        chk("rst_m1_datain", M1_DataIn, 0);
        chk("rst_p_bus", {P_Sel, P_Write, P_Address, P_DataOut}, 0);
        chk("rst_state", DebugState, IDLE);
        Reset = 1'b0;
        tick();

        // fairness from reset: both requesting, grants M0,M1,M0,M1
        for (int g = 0; g < 2; g++) begin
            req_wr[0] = 1'b0; req_addr[0] = AW'(10 + 2 * g);
            req_wr[1] = 1'b0; req_addr[1] = AW'(11 + 2 * g);
            push_exp(1'b0, 1'b0, 32'hA000_0000 + g, 2, 0, 32'hA000_0000 + g);
            push_exp(1'b1, 1'b0, 32'hB000_0000 + g, 3, 0, 32'hB000_0000 + g);
            run_group(1'b1, 1'b1, 2);
        end

        // directed single-master table
        for (int i = 0; i < 7; i++) begin
            logic m;
            m = vecs[i].m;
            req_wr[m] = vecs[i].wr; req_addr[m] = vecs[i].addr; req_data[m] = vecs[i].data;
            push_exp(m, vecs[i].exp_err, vecs[i].exp_keep ? pred_din[m] : vecs[i].exp_din,
                     vecs[i].exp_lat, vecs[i].waits, vecs[i].rd);
            run_group(m == 1'b0, m == 1'b1, 1);
        end

        // reset in the second ACCESS cycle: silent abort, outputs cleared
        req_wr[0] = 1'b0; req_addr[0] = 9'd5;
        M0_Req = 1'b1; M0_Write = 1'b0; M0_Address = 9'd5; P_Ready = 1'b0;
        tick();
        tick();
        chk("abort_psel_before", P_Sel, 1);
        Reset = 1'b1;
        tick();
        chk("abort_acks", {M1_Ack, M0_Ack, M1_Err, M0_Err}, 4'b0);
        chk("abort_m0_datain", M0_DataIn, 0);
        chk("abort_m1_datain", M1_DataIn, 0);
        chk("abort_p_bus", {P_Sel, P_Write, P_Address, P_DataOut}, 0);
        M0_Req = 1'b0;
        Reset = 1'b0;
        clear_model();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_ack", {M1_Ack, M0_Ack}, 2'b00);
        end
        req_wr[0] = 1'b0; req_addr[0] = 9'd20;
        req_wr[1] = 1'b1; req_addr[1] = 9'd21; req_data[1] = 32'h0F0F_0F0F;
        push_exp(1'b0, 1'b0, 32'h0000_0020, 3, 1, 32'h0000_0020);
        push_exp(1'b1, 1'b0, pred_din[1], 3, 0, 32'h0);
        run_group(1'b1, 1'b1, 2);

        // randomized groups against the reference model
        for (int g = 0; g < 60; g++) begin
            int want;
            want = $urandom_range(1, 3);
            for (int i = 0; i < 2; i++) begin
                req_wr[i]   = 1'($urandom_range(0, 1));
                req_addr[i] = AW'($urandom_range(0, 511));
                req_data[i] = $urandom;
            end
            model_group(want[0], want[1]);
            run_group(want[0], want[1], (want == 3) ? 2 : 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
